// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types, widths and address-check helper for the
//                data-memory responder and its word array.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // A request is bad when it is not word aligned or when any address bit
    // above the word-index field is set (it would otherwise alias).
    function automatic logic addr_is_bad(input logic [31:0] addr,
                                         input int unsigned idx_w);
        logic [31:0] hi;
        hi = addr >> (idx_w + 2);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_word_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_word_array
//  Description : DEPTH_WORDS x 32-bit storage with a byte-strobed synchronous
//                write and a registered read result.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk      in   clock
//    rst      in   synchronous active-low reset (read register only)
//    we_i     in   write the enabled lanes of wdata_i to word idx_i
//    wstrb_i  in   byte-lane enables for the write
//    re_i     in   capture word idx_i into the read register
//    clr_i    in   force the read register to zero
//    idx_i    in   word index
//    wdata_i  in   write data
//    rdata_o  out  registered read data
// ============================================================================
module dmem_word_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we_i,
    input  logic [STRB_W-1:0]              wstrb_i,
    input  logic                           re_i,
    input  logic                           clr_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [WORD_W-1:0]              wdata_i,
    output logic [WORD_W-1:0]              rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read and write are never requested on the same edge by the responder.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Responder end of the data-memory load/store interface.
//                Accepts one request at a time, inserts WAIT_CYCLES wait
//                states, then returns read data or a write acknowledgement.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock
//    rst        in   synchronous active-low reset
//    req_valid  in   request present
//    req_ready  out  responder idle and out of reset
//    req_write  in   1 = store, 0 = load
//    req_addr   in   byte address
//    req_wdata  in   store data
//    req_wstrb  in   store byte-lane enables
//    rsp_valid  out  response present
//    rsp_ready  in   initiator takes the response
//    rsp_rdata  out  load data (0 for stores and errors)
//    rsp_err    out  misaligned or out-of-range request
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic               write_q;
    logic               bad_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [STRB_W-1:0]  wstrb_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               commit;

    assign req_ready = rst && (state_q == IDLE);

    // The counter is loaded with WAIT_CYCLES and the commit happens on the
    // edge where it is already zero, giving rsp_valid WAIT_CYCLES+1 edges
    // after acceptance. Gating with rst keeps an abandoned store unwritten.
    assign commit = rst && (state_q == WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        bad_q   <= addr_is_bad(req_addr, IDX_W);
                        idx_q   <= req_addr[IDX_W+1:2];
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bad_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (commit && write_q && !bad_q),
        .wstrb_i (wstrb_q),
        .re_i    (commit && !write_q && !bad_q),
        .clr_i   (commit && (write_q || bad_q)),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (rsp_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench. Three responders share clock
//                and reset: index 0 has WAIT_CYCLES=1, index 1 has 3,
//                index 2 has 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wstrb [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .req_wstrb(req_wstrb[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input string tag);
        int n;
        n = 0;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_wstrb[d] = ws;
        req_valid[d] = 1'b1;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(n < 50), 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        check({tag, "_busy"}, 32'(req_ready[d]), 32'd0);
    endtask

    task automatic do_txn(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input string tag);
        int lat;
        lat = 0;
        rsp_ready[d] = 1'b1;
        issue(d, w, a, wd, ws, tag);
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rsp_rdata[d], exp_rdata);
        check({tag, "_err"},   32'(rsp_err[d]), 32'(exp_err));
        @(negedge clk);
        check({tag, "_done"},  32'(rsp_valid[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            req_wstrb[i] = 4'd0;
            rsp_ready[i] = 1'b1;
        end

        // Reset hold
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready[0]), 32'd0);
            check("rst_valid", 32'(rsp_valid[0]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready[0]), 32'd1);
        check("post_rst_valid", 32'(rsp_valid[0]), 32'd0);
        check("post_rst_rdata", rsp_rdata[0], 32'd0);
        check("post_rst_err",   32'(rsp_err[0]), 32'd0);

        // WAIT_CYCLES = 1: store/load, strobes, errors
        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2, "st10");
        do_txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2, "ld10");
        do_txn(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0,        1'b0, 2, "st_b1");
        do_txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 2, "ld_b1");
        do_txn(0, 1'b1, 32'h10, 32'h11223344, 4'h0, 32'h0,        1'b0, 2, "st_b0");
        do_txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 2, "ld_b0");
        do_txn(0, 1'b0, 32'h13, 32'h0,        4'h0, 32'h0,        1'b1, 2, "ld_mis");
        do_txn(0, 1'b1, 32'h0,  32'h0BADC0DE, 4'hF, 32'h0,        1'b0, 2, "st0");
        do_txn(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0,      1'b1, 2, "st_oor");
        do_txn(0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h0BADC0DE, 1'b0, 2, "ld0");

        // Backpressure in RESP
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, "bp");
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_lat", 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_hold_rdata", rsp_rdata[0], 32'hDEADBEAA);
            check("bp_hold_err",   32'(rsp_err[0]), 32'd0);
            check("bp_hold_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_rel_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp_rel_ready", 32'(req_ready[0]), 32'd1);
        check("bp_rel_rdata", rsp_rdata[0], 32'hDEADBEAA);

        // WAIT_CYCLES = 3: reset during WAIT abandons the store
        do_txn(1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 4, "w3_st");
        issue(1, 1'b1, 32'h20, 32'h12345678, 4'hF, "w3_abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("w3_rst_ready", 32'(req_ready[1]), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("w3_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        do_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 4, "w3_ld");

        // WAIT_CYCLES = 0
        do_txn(2, 1'b1, 32'h4, 32'h01020304, 4'hF, 32'h0,        1'b0, 1, "w0_st");
        do_txn(2, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h6, 32'h0,        1'b0, 1, "w0_stb");
        do_txn(2, 1'b0, 32'h4, 32'h0,        4'h0, 32'h01FFFF04, 1'b0, 1, "w0_ld");

        // Reset during RESP drops rsp_valid on that edge
        rsp_ready[2] = 1'b0;
        issue(2, 1'b0, 32'h4, 32'h0, 4'h0, "rresp");
        @(negedge clk);
        check("rresp_valid", 32'(rsp_valid[2]), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rresp_drop", 32'(rsp_valid[2]), 32'd0);
        rst = 1'b1;
        rsp_ready[2] = 1'b1;
        @(negedge clk);
        check("rresp_idle", 32'(req_ready[2]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
